pacman_life_ctrl: RTL
=====================

Name: pacman_life_ctrl

Overview:
- Game-flow sequencer for the pacman movement datapath.
- Owns lives, level and round timing. Drives the pacman block's isDefeated (respawn to centre) and death (freeze motion) inputs.
- Also drives the ghost freeze line from ghost-hit and level-done events, so motion, respawn and game-over are never asserted in conflict.
- Runs in the frame_clk domain; one state step per frame.

Parameters:
START_LIVES, 3, lives loaded at reset and on restart (1..7)
READY_FRAMES, 120, frames held frozen before play starts (1..255)
DEATH_FRAMES, 60, frames of death freeze after a ghost hit (1..255)
RESPAWN_FRAMES, 2, frames isDefeated is held high (1..255)
CLEAR_FRAMES, 90, frames of freeze after level cleared (1..255)
START_KEY, 8'h2C, keycode that restarts from game over

Ports:
frame_clk  in  1  frame clock; all state changes on its rising edge
Reset  in  1  synchronous, active-high reset
keycode  in  8  current keyboard keycode
ghost_hit  in  1  level: pacman overlaps a non-frightened ghost this frame
level_done  in  1  level: dot counter is zero
isDefeated  out  1  to pacman: recentre and clear motion
death  out  1  to pacman: freeze motion
ghosts_frozen  out  1  to ghost movers: hold position
game_over  out  1  game-over display enable
life_lost  out  1  one-frame pulse when a life is deducted
lives  out  3  remaining lives
level  out  4  current level, 0-based
state_code  out  3  current state encoding (debug/HUD)

Behaviour:
- Interface: one clock, frame_clk. Reset is synchronous and active-high. Reset overrides every other input on that edge, including mid-sequence.
- Reset values:
  - state READY, timer 0, lives START_LIVES, level 0.
  - death 1, isDefeated 0, ghosts_frozen 1, game_over 0, life_lost 0, state_code 0.
- State encoding: READY=0, PLAY=1, DYING=2, RESPAWN=3, CLEAR=4, GAME_OVER=5. Codes 6 and 7 go to READY on the next edge.
- Outputs death, isDefeated, ghosts_frozen, game_over and state_code are Moore decodes of the registered state.
  - death=1 in READY, DYING, CLEAR, GAME_OVER.
  - isDefeated=1 only in RESPAWN. It is never high together with death.
  - ghosts_frozen=1 in every state except PLAY.
  - game_over=1 only in GAME_OVER.
- Timer: 8-bit. Cleared to 0 on every state transition. Otherwise increments by 1 each frame in READY, DYING, RESPAWN and CLEAR. A state with duration N exits on the edge where timer==N-1, so the state lasts exactly N frames.
- Transitions:
  - READY -> PLAY after READY_FRAMES.
  - PLAY -> DYING when ghost_hit=1. ghost_hit has priority when ghost_hit and level_done are both high.
  - PLAY -> CLEAR when level_done=1 and ghost_hit=0.
  - DYING exit after DEATH_FRAMES:
    - lives is decremented and life_lost pulses high for exactly the frame after the exit edge.
    - If the pre-decrement value of lives was 1, go to GAME_OVER (lives becomes 0).
    - Otherwise go to RESPAWN.
  - RESPAWN -> READY after RESPAWN_FRAMES.
  - CLEAR exit after CLEAR_FRAMES: level increments, saturating at 15; go to RESPAWN.
  - GAME_OVER -> READY when keycode==START_KEY. On that edge lives reloads START_LIVES and level clears to 0. Any other keycode keeps GAME_OVER.
- Inputs are ignored outside the states that examine them:
  - ghost_hit and level_done only in PLAY.
  - keycode only in GAME_OVER.
- lives never underflows. A decrement at lives==0 cannot occur because GAME_OVER is entered at 1.
- life_lost is registered and never asserted for more than one consecutive frame.

Test Plan:
1. Reset held 2 frames, then released -> death=1, ghosts_frozen=1, lives=3, level=0, state_code=0. Exactly 120 frames later: state_code=1, death=0, ghosts_frozen=0.
2. In PLAY, ghost_hit pulsed 1 frame -> state 2 for 60 frames (death=1). Then life_lost=1 for 1 frame and lives=2. State 3 with isDefeated=1 for 2 frames, then state 0.
3. Three ghost hits from a fresh game -> third DYING exits to GAME_OVER: lives=0, game_over=1, death=1, isDefeated never asserted. keycode=8'h04 keeps state 5. keycode=8'h2C gives state 0, lives=3, level=0.
4. In PLAY, ghost_hit=1 and level_done=1 on the same frame -> state 2 (DYING), level unchanged.
5. level_done=1 in PLAY -> state 4 for 90 frames, then level=1 and state 3 then 0. Repeated to level 15 -> stays 15.
6. Reset asserted on frame 30 of DYING -> next frame state 0, lives=3, life_lost=0, timer restarts (PLAY entered 120 frames later).

Source files
------------

// File: rtl/pacman_life_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pacman_life_ctrl
// Brief    : Game-flow sequencer owning lives, level and round timing.
// Revision : 1.0 - initial release
// ============================================================================
module pacman_life_ctrl #(
  parameter int unsigned START_LIVES    = 3,
  parameter int unsigned READY_FRAMES   = 120,
  parameter int unsigned DEATH_FRAMES   = 60,
  parameter int unsigned RESPAWN_FRAMES = 2,
  parameter int unsigned CLEAR_FRAMES   = 90,
  parameter logic [7:0]  START_KEY      = 8'h2C
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       ghost_hit,
  input  logic       level_done,
  output logic       isDefeated,
  output logic       death,
  output logic       ghosts_frozen,
  output logic       game_over,
  output logic       life_lost,
  output logic [2:0] lives,
  output logic [3:0] level,
  output logic [2:0] state_code
);

  typedef enum logic [2:0] {
    S_READY     = 3'd0,
    S_PLAY      = 3'd1,
    S_DYING     = 3'd2,
    S_RESPAWN   = 3'd3,
    S_CLEAR     = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  localparam logic [7:0] c_READY_LAST   = 8'(READY_FRAMES - 1);
  localparam logic [7:0] c_DEATH_LAST   = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] c_RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] c_CLEAR_LAST   = 8'(CLEAR_FRAMES - 1);
  localparam logic [2:0] c_START_LIVES  = 3'(START_LIVES);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_timer;
  logic [2:0] r_lives;
  logic [3:0] r_level;
  logic       r_life_lost;
  logic       w_dying_exit;
  logic       w_clear_exit;
  logic       w_restart;
  logic       w_timer_run;

  always_comb begin
    w_state_next = r_state;
    w_dying_exit = 1'b0;
    w_clear_exit = 1'b0;
    w_restart    = 1'b0;
    w_timer_run  = 1'b0;
    case (r_state)
      S_READY: begin
        w_timer_run = 1'b1;
        if (r_timer == c_READY_LAST) w_state_next = S_PLAY;
      end
      S_PLAY: begin
        // A hit wins over a simultaneous level clear.
        if (ghost_hit)       w_state_next = S_DYING;
        else if (level_done) w_state_next = S_CLEAR;
      end
      S_DYING: begin
        w_timer_run = 1'b1;
        if (r_timer == c_DEATH_LAST) begin
          w_dying_exit = 1'b1;
          w_state_next = (r_lives == 3'd1) ? S_GAME_OVER : S_RESPAWN;
        end
      end
      S_RESPAWN: begin
        w_timer_run = 1'b1;
        if (r_timer == c_RESPAWN_LAST) w_state_next = S_READY;
      end
      S_CLEAR: begin
        w_timer_run = 1'b1;
        if (r_timer == c_CLEAR_LAST) begin
          w_clear_exit = 1'b1;
          w_state_next = S_RESPAWN;
        end
      end
      S_GAME_OVER: begin
        if (keycode == START_KEY) begin
          w_restart    = 1'b1;
          w_state_next = S_READY;
        end
      end
      default: w_state_next = S_READY;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state     <= S_READY;
      r_timer     <= 8'd0;
      r_lives     <= c_START_LIVES;
      r_level     <= 4'd0;
      r_life_lost <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_life_lost <= w_dying_exit;
      if (w_state_next != r_state) r_timer <= 8'd0;
      else if (w_timer_run)        r_timer <= r_timer + 8'd1;
      if (w_dying_exit)   r_lives <= r_lives - 3'd1;
      else if (w_restart) r_lives <= c_START_LIVES;
      if (w_clear_exit && (r_level != 4'd15)) r_level <= r_level + 4'd1;
      else if (w_restart)                     r_level <= 4'd0;
    end
  end

  always_comb begin
    death         = (r_state == S_READY) || (r_state == S_DYING) ||
                    (r_state == S_CLEAR) || (r_state == S_GAME_OVER);
    isDefeated    = (r_state == S_RESPAWN);
    ghosts_frozen = (r_state != S_PLAY);
    game_over     = (r_state == S_GAME_OVER);
  end

  assign life_lost  = r_life_lost;
  assign lives      = r_lives;
  assign level      = r_level;
  assign state_code = r_state;

endmodule
`default_nettype wire
